perm_bits_iter: RTL and testbench
=================================

// Module: perm_bits_iter
// PURPOSE
//  Parametrised, iterative successor of the fixed 4x16-bit bit-permutation layer. Takes a block of G
//  words of G*G bits each, applies the lane-dependent bit permutation (forward or inverse) a
//  programmable number of rounds, one round per clock, behind valid/ready handshakes on both sides.
//  Sits between the MAC state register and the substitution layer; G=4 reproduces the existing layer.
// PARAMETERS
//  G           4   group size; lanes = G, word width W = G*G, block width B = G*W
//  MAX_ROUNDS  15  largest round count accepted; count port width CW = $clog2(MAX_ROUNDS+1)
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    input block + controls valid
//  in_ready   out  1    block accepted on cycle with in_valid & in_ready
//  in_data    in   B    lane w = in_data[w*W +: W]
//  in_inv     in   1    0 = forward permutation, 1 = inverse
//  in_count   in   CW   rounds to apply (0 = pass-through)
//  abort      in   1    synchronous flush to IDLE
//  out_valid  out  1    result valid, held until out_ready
//  out_ready  in   1    downstream accepts result
//  out_data   out  B    permuted block, same lane packing as in_data
//  busy       out  1    high in BUSY
// BEHAVIOUR
//  - Forward round, lane w, bit index G*k+j (0<=k,j<G): dest bit = G*((w-j) mod G) + k. Inverse round
//    is the exact inverse map: src bit G*m+k -> dest G*k+((w-m) mod G). Lanes never mix.
//  - FSM IDLE/BUSY/DONE. Reset: state IDLE, data reg 0, round counter 0, out_valid 0, busy 0.
//  - in_ready = (IDLE | (DONE & out_ready)) & ~rst; forced 0 in BUSY.
//  - Accept at edge T: load data reg, inv bit, counter = in_count; go BUSY if in_count!=0, else DONE.
//  - BUSY: each cycle data reg <= round(data reg), counter--; counter reaching 0 -> DONE same edge.
//  - Latency: out_valid first high cycle T+1+in_count. inv latched at accept; in_inv ignored after.
//  - DONE: out_valid=1, out_data = data reg, stable until out_ready. out_ready without new accept
//    -> IDLE. DONE & out_ready & in_valid same cycle -> result retired and new block accepted, no bubble.
//  - out_data = data reg at all times; only meaningful when out_valid.
//  - abort (any state) -> IDLE next edge, out_valid 0, data reg unchanged; abort beats simultaneous
//    accept (in_ready still shows 1 but block is dropped; source must not assert both).
//  - Async rst mid-BUSY/DONE: immediate return to reset values, in-flight block lost.
//  - in_count is CW bits wide, so values > MAX_ROUNDS are impossible when MAX_ROUNDS = 2^CW-1;
//    otherwise counts above MAX_ROUNDS saturate to MAX_ROUNDS at accept.
// TESTING
//  1 G=4, lane0=16'h0002, fwd, count=1 -> out lane0=16'h1000 at T+2; other lanes 0.
//  2 G=4, lane0=16'h0002, fwd, count=2 -> lane0=16'h0008 at T+3; then inv, count=2 on 16'h0008
//    -> 16'h0002.
//  3 G=4, lane1=16'h0001, fwd, count=0 -> lane1=16'h0001 at T+1 (pass-through); count=1
//    -> lane1=16'h0010.
//  4 Random 64-bit blocks, count 1..15, fwd then inv with same count -> original block; all
//    results match software model of the lane map, per round.
//  5 Back-to-back: hold out_ready=1, in_valid=1 -> one accept per count+1 cycles, no lost/dup blocks;
//    stall out_ready 5 cycles -> out_data stable, in_ready=0.
//  6 abort in BUSY cycle 2 of count=8 -> IDLE next edge, no out_valid; rst pulse mid-BUSY
//    -> outputs 0 immediately, next block processed correctly.

Source files
------------

// File: rtl/perm_bits_iter_if.sv
// Handshake and data bundle for the iterative bit-permutation layer.
// The master side sources blocks and sinks results; the slave side is the permutation engine.
interface perm_bits_iter_if #(
    parameter int unsigned G          = 4,
    parameter int unsigned MAX_ROUNDS = 15
);
    localparam int unsigned W  = G * G;
    localparam int unsigned B  = G * W;
    localparam int unsigned CW = $clog2(MAX_ROUNDS + 1);

    logic          in_valid;
    logic          in_ready;
    logic [B-1:0]  in_data;
    logic          in_inv;
    logic [CW-1:0] in_count;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [B-1:0]  out_data;
    logic          busy;

    modport master (
        output in_valid, in_data, in_inv, in_count, abort, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_inv, in_count, abort, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/perm_bits_iter.sv
// Iterative lane-local bit permutation: applies the forward or inverse round map a
// programmable number of times, one round per clock, behind valid/ready on both sides.
module perm_bits_iter #(
    parameter int unsigned G          = 4,
    parameter int unsigned MAX_ROUNDS = 15
) (
    input  logic            clk,
    input  logic            rst,
    perm_bits_iter_if.slave bus
);
    localparam int unsigned W  = G * G;
    localparam int unsigned B  = G * W;
    localparam int unsigned CW = $clog2(MAX_ROUNDS + 1);
    localparam bit SATURATE    = (MAX_ROUNDS < ((2 ** CW) - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [B-1:0]  data_q, data_d;
    logic          inv_q, inv_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, busy_q;

    logic [B-1:0]  round_fwd;
    logic [B-1:0]  round_inv;
    logic [CW-1:0] count_sat;
    logic          in_ready_c;
    logic          accept;

    // One round is pure wiring: each lane is permuted independently with constant indices.
    for (genvar w = 0; w < G; w++) begin : g_lane
        for (genvar a = 0; a < G; a++) begin : g_row
            for (genvar b = 0; b < G; b++) begin : g_col
                localparam int unsigned SRC = w * W + G * a + b;
                localparam int unsigned FWD = w * W + G * ((w - b + G) % G) + a;
                localparam int unsigned INV = w * W + G * b + ((w - a + G) % G);
                assign round_fwd[FWD] = data_q[SRC];
                assign round_inv[INV] = data_q[SRC];
            end
        end
    end

    // Counts above MAX_ROUNDS only exist when the port is wider than the limit needs.
    if (SATURATE) begin : g_sat
        assign count_sat = (bus.in_count > CW'(MAX_ROUNDS)) ? CW'(MAX_ROUNDS) : bus.in_count;
    end else begin : g_nosat
        assign count_sat = bus.in_count;
    end

    assign in_ready_c = ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready)) && !rst;
    assign accept     = in_ready_c && bus.in_valid;

    // Next-state and datapath update; abort overrides everything and keeps the data register.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        inv_d   = inv_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    data_d  = bus.in_data;
                    inv_d   = bus.in_inv;
                    cnt_d   = count_sat;
                    state_d = (count_sat != '0) ? BUSY : DONE;
                end else if ((state_q == DONE) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                data_d = inv_q ? round_inv : round_fwd;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d = IDLE;
            data_d  = data_q;
            inv_d   = inv_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            inv_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            inv_q       <= inv_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == BUSY);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_perm_bits_iter.sv
// Directed self-checking bench for perm_bits_iter at G=4, MAX_ROUNDS=15.
module tb_perm_bits_iter;
    localparam int unsigned G          = 4;
    localparam int unsigned MAX_ROUNDS = 15;
    localparam int unsigned W          = 16;
    localparam int unsigned B          = 64;
    localparam int unsigned CW         = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    perm_bits_iter_if #(.G(G), .MAX_ROUNDS(MAX_ROUNDS)) bus ();

    perm_bits_iter #(.G(G), .MAX_ROUNDS(MAX_ROUNDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Gather form of the lane map: dest bit G*m+k takes src bit G*k+((w-m) mod G).
    function automatic logic [B-1:0] model_fwd(input logic [B-1:0] x);
        logic [B-1:0] y;
        y = '0;
        for (int w = 0; w < G; w++)
            for (int m = 0; m < G; m++)
                for (int k = 0; k < G; k++)
                    y[6'(w * W + G * m + k)] = x[6'(w * W + G * k + ((w - m + G) % G))];
        return y;
    endfunction

    function automatic logic [B-1:0] model_inv(input logic [B-1:0] x);
        logic [B-1:0] y;
        y = '0;
        for (int w = 0; w < G; w++)
            for (int k = 0; k < G; k++)
                for (int j = 0; j < G; j++)
                    y[6'(w * W + G * k + j)] = x[6'(w * W + G * ((w - j + G) % G) + k)];
        return y;
    endfunction

    function automatic logic [B-1:0] model_rounds(input logic [B-1:0] x, input logic inv, input int n);
        logic [B-1:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = inv ? model_inv(y) : model_fwd(y);
        return y;
    endfunction

    // Present one block and return one cycle after the accepting edge; controls are scrambled after.
    task automatic send(input logic [B-1:0] d, input logic inv, input logic [CW-1:0] c);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inv   = inv;
        bus.in_count = c;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        bus.in_inv   = ~inv;
        bus.in_count = '0;
    endtask

    // Latency counts from the accept cycle: 1 means out_valid in the cycle right after accept.
    task automatic wait_result(output logic [B-1:0] d, output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus.out_data;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); n_err++; end
        n_vec++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); n_err++; end
        n_vec++; if (bus.busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", bus.busy); n_err++; end
        n_vec++; if (bus.out_data !== 64'h0) begin $display("FAIL reset_out_data: got %h want 0", bus.out_data); n_err++; end
        rst = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); n_err++; end
        @(posedge clk); #1;
    endtask

    task automatic test_single_round();
        logic [B-1:0] r;
        int lat;
        send(64'h0000_0000_0000_0002, 1'b0, 4'd1);
        wait_result(r, lat);
        n_vec++; if (r !== 64'h0000_0000_0000_1000) begin $display("FAIL fwd1_data: got %h want %h", r, 64'h1000); n_err++; end
        n_vec++; if (lat !== 2) begin $display("FAIL fwd1_latency: got %0d want 2", lat); n_err++; end
        retire();
    endtask

    task automatic test_two_rounds();
        logic [B-1:0] r;
        int lat;
        send(64'h0000_0000_0000_0002, 1'b0, 4'd2);
        wait_result(r, lat);
        n_vec++; if (r !== 64'h0000_0000_0000_0008) begin $display("FAIL fwd2_data: got %h want %h", r, 64'h8); n_err++; end
        n_vec++; if (lat !== 3) begin $display("FAIL fwd2_latency: got %0d want 3", lat); n_err++; end
        retire();
        send(64'h0000_0000_0000_0008, 1'b1, 4'd2);
        wait_result(r, lat);
        n_vec++; if (r !== 64'h0000_0000_0000_0002) begin $display("FAIL inv2_data: got %h want %h", r, 64'h2); n_err++; end
        n_vec++; if (lat !== 3) begin $display("FAIL inv2_latency: got %0d want 3", lat); n_err++; end
        retire();
    endtask

    task automatic test_pass_through();
        logic [B-1:0] r;
        int lat;
        send(64'h0000_0000_0001_0000, 1'b0, 4'd0);
        wait_result(r, lat);
        n_vec++; if (r !== 64'h0000_0000_0001_0000) begin $display("FAIL pass_data: got %h want %h", r, 64'h1_0000); n_err++; end
        n_vec++; if (lat !== 1) begin $display("FAIL pass_latency: got %0d want 1", lat); n_err++; end
        retire();
        send(64'h0000_0000_0001_0000, 1'b0, 4'd1);
        wait_result(r, lat);
        n_vec++; if (r !== 64'h0000_0000_0010_0000) begin $display("FAIL lane1_fwd_data: got %h want %h", r, 64'h10_0000); n_err++; end
        retire();
    endtask

    task automatic test_random_roundtrip();
        logic [B-1:0] d, r, r2;
        logic [CW-1:0] c;
        int lat;
        for (int i = 0; i < 6; i++) begin
            d = {$urandom(), $urandom()};
            c = (i == 0) ? 4'd15 : CW'($urandom_range(15, 1));
            send(d, 1'b0, c);
            wait_result(r, lat);
            n_vec++; if (r !== model_rounds(d, 1'b0, int'(c))) begin $display("FAIL rand_fwd[%0d]: got %h want %h", i, r, model_rounds(d, 1'b0, int'(c))); n_err++; end
            n_vec++; if (lat !== int'(c) + 1) begin $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, int'(c) + 1); n_err++; end
            retire();
            send(r, 1'b1, c);
            wait_result(r2, lat);
            n_vec++; if (r2 !== d) begin $display("FAIL rand_roundtrip[%0d]: got %h want %h", i, r2, d); n_err++; end
            retire();
        end
    endtask

    task automatic test_back_to_back();
        logic [B-1:0] blk [4];
        logic [B-1:0] exp_q [4];
        int acc_cyc [4];
        int n_acc, n_out;
        n_acc = 0;
        n_out = 0;
        blk[0] = 64'h0123_4567_89ab_cdef;
        blk[1] = 64'hfedc_ba98_7654_3210;
        blk[2] = 64'h8000_0001_00ff_f00f;
        blk[3] = 64'h5a5a_a5a5_3c3c_c3c3;
        for (int i = 0; i < 4; i++) exp_q[i] = model_rounds(blk[i], 1'b0, 2);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = blk[0];
        bus.in_inv    = 1'b0;
        bus.in_count  = 4'd2;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic acc;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                n_vec++;
                if (n_out >= 4 || bus.out_data !== exp_q[n_out]) begin
                    $display("FAIL b2b_data[%0d]: got %h want %h", n_out, bus.out_data, exp_q[n_out]);
                    n_err++;
                end
                n_out++;
            end
            if (acc && n_acc < 4) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (n_acc < 4) bus.in_data = blk[n_acc];
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_vec++; if (n_out !== 4) begin $display("FAIL b2b_out_count: got %0d want 4", n_out); n_err++; end
        n_vec++; if (n_acc !== 4) begin $display("FAIL b2b_acc_count: got %0d want 4", n_acc); n_err++; end
        for (int i = 1; i < n_acc; i++) begin
            n_vec++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 3) begin
                $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]);
                n_err++;
            end
        end
    endtask

    task automatic test_stall();
        logic [B-1:0] a, b, r, exp_a;
        int lat;
        a = 64'hdead_beef_0bad_f00d;
        b = 64'h1357_9bdf_2468_ace0;
        exp_a = model_rounds(a, 1'b0, 1);
        send(a, 1'b0, 4'd1);
        wait_result(r, lat);
        n_vec++; if (r !== exp_a) begin $display("FAIL stall_first: got %h want %h", r, exp_a); n_err++; end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_inv   = 1'b1;
        bus.in_count = 4'd3;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (bus.out_data !== exp_a) begin $display("FAIL stall_hold[%0d]: got %h want %h", i, bus.out_data, exp_a); n_err++; end
            n_vec++; if (bus.out_valid !== 1'b1) begin $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.out_valid); n_err++; end
            n_vec++; if (bus.in_ready !== 1'b0) begin $display("FAIL stall_in_ready[%0d]: got %b want 0", i, bus.in_ready); n_err++; end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin $display("FAIL stall_release: got %b want 1", bus.in_ready); n_err++; end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        wait_result(r, lat);
        n_vec++; if (r !== model_rounds(b, 1'b1, 3)) begin $display("FAIL stall_second: got %h want %h", r, model_rounds(b, 1'b1, 3)); n_err++; end
        n_vec++; if (lat !== 4) begin $display("FAIL stall_second_latency: got %0d want 4", lat); n_err++; end
        retire();
    endtask

    task automatic test_abort_reset();
        logic [B-1:0] d, r;
        int lat, seen;
        d = 64'h0f0f_1234_8001_7ffe;
        send(d, 1'b0, 4'd8);
        n_vec++; if (bus.busy !== 1'b1) begin $display("FAIL busy_flag: got %b want 1", bus.busy); n_err++; end
        n_vec++; if (bus.in_ready !== 1'b0) begin $display("FAIL busy_in_ready: got %b want 0", bus.in_ready); n_err++; end
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        n_vec++; if (bus.busy !== 1'b0) begin $display("FAIL abort_busy: got %b want 0", bus.busy); n_err++; end
        n_vec++; if (bus.in_ready !== 1'b1) begin $display("FAIL abort_idle: got %b want 1", bus.in_ready); n_err++; end
        n_vec++; if (bus.out_data !== model_rounds(d, 1'b0, 1)) begin $display("FAIL abort_data_kept: got %h want %h", bus.out_data, model_rounds(d, 1'b0, 1)); n_err++; end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        n_vec++; if (seen !== 0) begin $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); n_err++; end

        send(d, 1'b0, 4'd8);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_vec++; if (bus.busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", bus.busy); n_err++; end
        n_vec++; if (bus.out_data !== 64'h0) begin $display("FAIL rst_data: got %h want 0", bus.out_data); n_err++; end
        n_vec++; if (bus.in_ready !== 1'b0) begin $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); n_err++; end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(64'h0000_0000_0000_0002, 1'b0, 4'd1);
        wait_result(r, lat);
        n_vec++; if (r !== 64'h0000_0000_0000_1000) begin $display("FAIL post_rst_data: got %h want %h", r, 64'h1000); n_err++; end
        n_vec++; if (lat !== 2) begin $display("FAIL post_rst_latency: got %0d want 2", lat); n_err++; end
        retire();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_inv    = 1'b0;
        bus.in_count  = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_round();
        test_two_rounds();
        test_pass_through();
        test_random_roundtrip();
        test_back_to_back();
        test_stall();
        test_abort_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
